// File: rtl/fetch_bpred.sv
// fetch_bpred -- fetch-stage program counter with branch prediction.
//
// This block owns the fetch PC. Every cycle it predicts the next fetch address.
// The prediction comes from a direct-mapped branch target buffer (BTB). Each
// BTB entry holds a saturating direction counter.
//
// EX-stage corrections arrive as a redirect. Redirect takes priority over the
// prediction and over stall. Resolved branches train the table through the
// upd_* port.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   reset        synchronous active-high reset; dominates every other input
//   stall        hold the PC for this cycle (load-use hazard)
//   redirect     load redirect_pc (with bits [1:0] cleared) into the PC
//   redirect_pc  corrected fetch address
//   upd_valid    EX resolved a control-transfer instruction this cycle
//   upd_pc       PC of the resolved instruction
//   upd_taken    resolved direction
//   upd_target   resolved target address
//   pc           current fetch PC (registered)
//   pred_taken   BTB hit with a counter in the taken half (combinational)
//   pred_target  predicted target, or pc+4 when not predicted taken
//   next_pc      value the PC loads on the next rising edge
//   mispredicts  saturating count of redirect cycles

module fetch_bpred #(
    parameter int PC_W     = 9,
    parameter int ENTRIES  = 16,
    parameter int CTR_W    = 2,
    parameter int RESET_PC = 0,
    parameter int PERF_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    output logic [PC_W-1:0]   pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    output logic [PC_W-1:0]   next_pc,
    output logic [PERF_W-1:0] mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    // Counter encodings.
    // CTR_MAX: strongest taken state.
    // CTR_WT:  weakly taken, the value given to a newly allocated entry.
    // CTR_WNT: weakly not taken, the value after reset.
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(2 ** (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(2 ** (CTR_W - 1) - 1);

    logic [PC_W-1:0]   pc_reg;
    logic [PC_W-1:0]   pc_next;
    logic [PERF_W-1:0] mispredicts_reg;

    // Per-entry contents, gathered from the generate blocks below so that
    // they can be read with a variable index.
    logic             entry_valid  [ENTRIES];
    logic [TAG_W-1:0] entry_tag    [ENTRIES];
    logic [PC_W-1:0]  entry_target [ENTRIES];
    logic [CTR_W-1:0] entry_ctr    [ENTRIES];

    // Lookup on the current PC.
    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_hit;
    logic [PC_W-1:0]  pc_plus4;

    assign rd_idx   = pc_reg[IDX_W+1:2];
    assign rd_tag   = pc_reg[PC_W-1:IDX_W+2];
    assign rd_hit   = entry_valid[rd_idx] && (entry_tag[rd_idx] == rd_tag);
    assign pc_plus4 = pc_reg + PC_W'(4);   // wraps modulo 2^PC_W

    assign pred_taken  = rd_hit && entry_ctr[rd_idx][CTR_W-1];
    assign pred_target = pred_taken ? entry_target[rd_idx] : pc_plus4;

    // Update-side decode.
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[PC_W-1:IDX_W+2];
    assign upd_hit = entry_valid[upd_idx] && (entry_tag[upd_idx] == upd_tag);

    // The byte-offset bits of both incoming addresses are deliberately ignored.
    logic unused_low_bits;
    assign unused_low_bits = ^{redirect_pc[1:0], upd_pc[1:0]};

    always_comb begin
        pc_next = pred_target;
        if (reset) begin
            pc_next = PC_W'(RESET_PC);
        end else if (redirect) begin
            pc_next = {redirect_pc[PC_W-1:2], 2'b00};
        end else if (stall) begin
            pc_next = pc_reg;
        end
    end

    always_ff @(posedge clk) begin
        pc_reg <= pc_next;
        if (reset) begin
            mispredicts_reg <= '0;
        end else if (redirect && (mispredicts_reg != {PERF_W{1'b1}})) begin
            mispredicts_reg <= mispredicts_reg + PERF_W'(1);
        end
    end

    // One register set per BTB entry. All bits are reset so that no X can
    // reach the lookup path. The table is written on the clock edge, so a
    // lookup and an update to the same index in the same cycle see the old
    // contents.
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             valid_reg;
            logic [TAG_W-1:0] tag_reg;
            logic [PC_W-1:0]  target_reg;
            logic [CTR_W-1:0] ctr_reg;
            logic             sel;

            assign sel = upd_valid && (upd_idx == IDX_W'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    ctr_reg    <= CTR_WNT;
                end else if (sel) begin
                    if (upd_hit) begin
                        if (upd_taken) begin
                            target_reg <= upd_target;
                            if (ctr_reg != CTR_MAX) begin
                                ctr_reg <= ctr_reg + CTR_W'(1);
                            end
                        end else if (ctr_reg != '0) begin
                            ctr_reg <= ctr_reg - CTR_W'(1);
                        end
                    end else if (upd_taken) begin
                        // A miss that resolved taken replaces the entry.
                        // A miss that resolved not taken leaves it alone.
                        valid_reg  <= 1'b1;
                        tag_reg    <= upd_tag;
                        target_reg <= upd_target;
                        ctr_reg    <= CTR_WT;
                    end
                end
            end

            assign entry_valid[gi]  = valid_reg;
            assign entry_tag[gi]    = tag_reg;
            assign entry_target[gi] = target_reg;
            assign entry_ctr[gi]    = ctr_reg;
        end
    endgenerate

    assign pc          = pc_reg;
    assign next_pc     = pc_next;
    assign mispredicts = mispredicts_reg;

endmodule

// File: tb/tb_fetch_bpred.sv
// Testbench for fetch_bpred.
//
// A stimulus process drives one transaction per cycle. For each transaction it
// pushes the expected outputs onto a queue. The expected values come from a
// behavioural model that keeps the branch history as plain integers. Each
// model entry remembers the word address of its owning branch.
//
// A separate monitor process pops one expectation per cycle. It compares that
// expectation against the DUT outputs, sampling between clock edges.

module tb_fetch_bpred;

    localparam int PC_W     = 9;
    localparam int ENTRIES  = 16;
    localparam int CTR_W    = 2;
    localparam int RESET_PC = 0;
    localparam int PERF_W   = 16;
    localparam int SPACE    = 1 << PC_W;
    localparam int CTR_TOP  = (1 << CTR_W) - 1;
    localparam int CTR_HALF = 1 << (CTR_W - 1);
    localparam int MIS_MAX  = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              upd_valid;
    logic [PC_W-1:0]   upd_pc;
    logic              upd_taken;
    logic [PC_W-1:0]   upd_target;
    logic [PC_W-1:0]   pc;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;
    logic [PC_W-1:0]   next_pc;
    logic [PERF_W-1:0] mispredicts;

    fetch_bpred #(
        .PC_W(PC_W), .ENTRIES(ENTRIES), .CTR_W(CTR_W),
        .RESET_PC(RESET_PC), .PERF_W(PERF_W)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .pc(pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .next_pc(next_pc), .mispredicts(mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int pc;
        bit pt;
        int ptgt;
        int npc;
        int mis;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference model state.
    int m_pc;
    int m_mis;
    bit m_valid [ENTRIES];
    int m_word  [ENTRIES];   // word address (pc/4) of the branch owning the slot
    int m_tgt   [ENTRIES];
    int m_ctr   [ENTRIES];

    function automatic int slot(input int a);
        return ((a % SPACE) / 4) % ENTRIES;
    endfunction

    function automatic void model_reset();
        m_pc  = RESET_PC;
        m_mis = 0;
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_word[i]  = 0;
            m_tgt[i]   = 0;
            m_ctr[i]   = CTR_HALF - 1;
        end
    endfunction

    task automatic step(input bit rst, input bit st, input bit rd, input int rpc,
                        input bit uv, input int upc, input bit ut, input int utgt);
        exp_t e;
        int   i;
        int   j;
        int   uw;
        bit   hit;

        @(negedge clk);
        reset       = rst;
        stall       = st;
        redirect    = rd;
        redirect_pc = PC_W'(rpc);
        upd_valid   = uv;
        upd_pc      = PC_W'(upc);
        upd_taken   = ut;
        upd_target  = PC_W'(utgt);

        // Expected outputs for this cycle, taken from the state before the edge.
        i      = slot(m_pc);
        hit    = m_valid[i] && (m_word[i] == m_pc / 4);
        e.n    = txn;
        e.pc   = m_pc;
        e.pt   = hit && (m_ctr[i] >= CTR_HALF);
        e.ptgt = e.pt ? m_tgt[i] : (m_pc + 4) % SPACE;
        e.npc  = rst ? RESET_PC : rd ? ((rpc % SPACE) / 4) * 4 : st ? m_pc : e.ptgt;
        e.mis  = m_mis;
        q.push_back(e);
        txn++;

        // Advance the model to its state after the edge.
        if (rst) begin
            model_reset();
        end else begin
            if (rd && m_mis < MIS_MAX) m_mis++;
            if (uv) begin
                j  = slot(upc);
                uw = (upc % SPACE) / 4;
                if (m_valid[j] && m_word[j] == uw) begin
                    if (ut) begin
                        m_ctr[j] = (m_ctr[j] < CTR_TOP) ? m_ctr[j] + 1 : CTR_TOP;
                        m_tgt[j] = utgt % SPACE;
                    end else begin
                        m_ctr[j] = (m_ctr[j] > 0) ? m_ctr[j] - 1 : 0;
                    end
                end else if (ut) begin
                    m_valid[j] = 1'b1;
                    m_word[j]  = uw;
                    m_tgt[j]   = utgt % SPACE;
                    m_ctr[j]   = CTR_HALF;
                end
            end
            m_pc = e.npc;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jump(input int a);
        step(0, 0, 1, a, 0, 0, 0, 0);
    endtask

    function automatic void cmp(input int n, input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL txn %0d %s: got 0x%0h expected 0x%0h", n, name, act, req);
        end
    endfunction

    // Monitor: one expectation per cycle, sampled 2 time units after the negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.n, "pc",          int'(pc),          e.pc);
                cmp(e.n, "pred_taken",  int'(pred_taken),  int'(e.pt));
                cmp(e.n, "pred_target", int'(pred_target), e.ptgt);
                cmp(e.n, "next_pc",     int'(next_pc),     e.npc);
                cmp(e.n, "mispredicts", int'(mispredicts), e.mis);
            end
        end
    end

    initial begin
        int r;
        int upc;
        int pool [6];

        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset, then a straight-line run from RESET_PC.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        // Stall twice at 0x10, then redirect while stalled.
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 'h43, 0, 0, 0, 0);
        // Allocate 0x20 -> 0x80 and fetch through it.
        step(0, 0, 0, 0, 1, 'h20, 1, 'h80);
        jump('h18);
        idle(3);
        // Two not-taken updates flip the prediction.
        step(0, 0, 0, 0, 1, 'h20, 0, 0);
        step(0, 0, 0, 0, 1, 'h20, 0, 0);
        jump('h20);
        idle(2);
        // Saturate taken, then one not-taken keeps the prediction taken.
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1, 'h20, 1, 'h80);
        step(0, 0, 0, 0, 1, 'h20, 0, 0);
        jump('h20);
        idle(2);
        // Aliasing: 0x60 evicts 0x20 from the same slot.
        step(0, 0, 0, 0, 1, 'h60, 1, 'h100);
        jump('h20);
        idle(1);
        jump('h60);
        idle(2);
        // Wrap at the top of the address space.
        jump('h1F0);
        idle(5);
        // Collision: update the slot of the current PC while stalled.
        jump('h08);
        step(0, 1, 0, 0, 1, m_pc, 1, 'h44);
        idle(3);
        // Reset during an update wipes the table.
        jump('h30);
        step(1, 0, 0, 0, 1, 'h30, 1, 'h88);
        jump('h60);
        idle(1);
        jump('h30);
        idle(2);

        // Randomized traffic concentrated on a few hot branches.
        pool[0] = 'h20; pool[1] = 'h60; pool[2] = 'h24;
        pool[3] = 'h1FC; pool[4] = 'h100; pool[5] = 'h140;
        for (int k = 0; k < 1500; k++) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 3))
                0:       upc = m_pc;
                1:       upc = (m_pc + 4) % SPACE;
                2:       upc = $urandom_range(0, SPACE - 1);
                default: upc = pool[$urandom_range(0, 5)];
            endcase
            step(r < 1, (r >= 1 && r < 12), (r >= 12 && r < 18),
                 $urandom_range(0, SPACE - 1),
                 $urandom_range(0, 2) != 0, upc, $urandom_range(0, 2) != 0,
                 pool[$urandom_range(0, 5)]);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
